seq_window_detector: RTL and testbench

SEQ_WINDOW_DETECTOR -- requirements
Module: seq_window_detector

---
 rtl/seq_window_pkg.sv | 17 +
 rtl/seq_match_core.sv | 46 ++++
 rtl/seq_window_detector.sv | 115 +++++++++++
 tb/tb_seq_window_detector.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_window_pkg.sv
// Shared constants and state encoding for the windowed sequence detector.
package seq_window_pkg;

    localparam int unsigned PAT_W_DEF  = 4;
    localparam int unsigned HIST_W_DEF = 16;
    localparam int unsigned CNT_W_DEF  = 8;

    // Legacy encodings kept as plain constants; the enum is built on them.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN
    } state_e;

endpackage

// File: rtl/seq_match_core.sv
// Shift register, fill counter and pattern comparator for one detection window.
module seq_match_core
    import seq_window_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             accept,
    input  logic             serialin,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             match
);

    localparam int unsigned       FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  shift;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  shift_next;

    // Candidate window: the last PAT_W-1 accepted bits plus the incoming bit.
    assign shift_next = {shift, serialin};
    assign match      = accept && (fill >= FILL_MAX) && (shift_next == pattern);

    // Shift accepted bits in; fill saturates, and a match restarts it when not overlapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift <= '0;
            fill  <= '0;
        end else if (clear) begin
            shift <= '0;
            fill  <= '0;
        end else if (accept) begin
            shift <= shift_next[PAT_W-2:0];
            if (match && !overlap) begin
                fill <= '0;
            end else if (fill != FILL_MAX) begin
                fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_window_detector.sv
// Windowed serial sequence detector: counts matches per window and hands the
// window result to a consumer over a valid/ready interface.
module seq_window_detector
    import seq_window_pkg::*;
#(
    parameter int unsigned PAT_W  = PAT_W_DEF,
    parameter int unsigned HIST_W = HIST_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              serialin,
    input  logic              bit_valid,
    input  logic [PAT_W-1:0]  pattern,
    input  logic              overlap_mode,
    input  logic              win_valid,
    output logic              seq_detected,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  res_count,
    output logic [HIST_W-1:0] res_hist,
    output logic              res_overrun
);

    state_e             state;
    logic               win_prev;
    logic [PAT_W-1:0]   pat_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   cnt;
    logic [HIST_W-1:0]  hist;

    logic               open_win;
    logic               close_win;
    logic               accept;
    logic               match;
    logic               handshake;

    assign open_win  = (state == IDLE) && win_valid && !win_prev;
    assign close_win = (state == RUN) && !win_valid;
    assign accept    = (state == RUN) && win_valid && bit_valid;
    assign handshake = res_valid && res_ready;

    seq_match_core #(
        .PAT_W(PAT_W)
    ) u_core (
        .clock   (clock),
        .reset   (reset),
        .clear   (open_win),
        .accept  (accept),
        .serialin(serialin),
        .pattern (pat_q),
        .overlap (ovl_q),
        .match   (match)
    );

    // Window FSM, edge detect on win_valid, and per-window latch of pattern/mode.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            win_prev <= 1'b1;
            pat_q    <= '0;
            ovl_q    <= 1'b0;
        end else begin
            win_prev <= win_valid;
            if (open_win) begin
                state <= RUN;
                pat_q <= pattern;
                ovl_q <= overlap_mode;
            end else if (close_win) begin
                state <= IDLE;
            end
        end
    end

    // Per-window match counter, match history and detection pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            hist         <= '0;
            seq_detected <= 1'b0;
        end else begin
            seq_detected <= match;
            if (open_win) begin
                cnt  <= '0;
                hist <= '0;
            end else if (accept) begin
                hist <= {hist[HIST_W-2:0], match};
                if (match && (cnt != '1)) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Result register: capture on window close, release on handshake, sticky overrun.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            res_valid   <= 1'b0;
            res_count   <= '0;
            res_hist    <= '0;
            res_overrun <= 1'b0;
        end else if (close_win) begin
            res_valid <= 1'b1;
            res_count <= cnt;
            res_hist  <= hist;
            if (res_valid && !res_ready) begin
                res_overrun <= 1'b1;
            end
        end else if (handshake) begin
            res_valid   <= 1'b0;
            res_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_window_detector.sv
// Scoreboard bench for seq_window_detector: directed windows push expected
// results; a negedge monitor pops and compares on every result handshake.
module tb_seq_window_detector;

    logic        clock = 1'b0;
    logic        reset;
    logic        serialin;
    logic        bit_valid;
    logic [3:0]  pattern;
    logic        overlap_mode;
    logic        win_valid;
    logic        seq_detected;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_count;
    logic [15:0] res_hist;
    logic        res_overrun;

    typedef struct packed {
        logic [7:0]  cnt;
        logic [15:0] hist;
        logic        ovr;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   pulse_cnt = 0;
    int   base;

    seq_window_detector #(
        .PAT_W (4),
        .HIST_W(16),
        .CNT_W (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .serialin    (serialin),
        .bit_valid   (bit_valid),
        .pattern     (pattern),
        .overlap_mode(overlap_mode),
        .win_valid   (win_valid),
        .seq_detected(seq_detected),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_count   (res_count),
        .res_hist    (res_hist),
        .res_overrun (res_overrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: count detection pulses, compare results on each handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && seq_detected === 1'b1) pulse_cnt++;
            if (reset === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got count=%0d hist=%0h with nothing expected", res_count, res_hist);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_count",   32'(res_count),   32'(e.cnt));
                    chk("sb_hist",    32'(res_hist),    32'(e.hist));
                    chk("sb_overrun", 32'(res_overrun), 32'(e.ovr));
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Opens a window; bit_valid on the opening cycle must be ignored, and
    // pattern/mode are corrupted afterwards to show they were latched.
    task automatic open_win(input logic [3:0] pat, input logic ov);
        win_valid = 1'b0;
        cyc();
        win_valid    = 1'b1;
        pattern      = pat;
        overlap_mode = ov;
        serialin     = 1'b1;
        bit_valid    = 1'b1;
        cyc();
        bit_valid    = 1'b0;
        serialin     = 1'b0;
        pattern      = ~pat;
        overlap_mode = ~ov;
    endtask

    task automatic send_bits(input string name, input logic [15:0] bits,
                             input logic [15:0] det, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            serialin  = bits[i];
            bit_valid = 1'b1;
            cyc();
            bit_valid = 1'b0;
            serialin  = 1'b0;
            chk(name, 32'(seq_detected), 32'(det[i]));
        end
    endtask

    task automatic close_win();
        win_valid = 1'b0;
        cyc();
    endtask

    task automatic handshake(input string name);
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        chk(name, 32'(res_valid), 32'd0);
    endtask

    initial begin
        reset        = 1'b0;
        serialin     = 1'b0;
        bit_valid    = 1'b0;
        pattern      = 4'h0;
        overlap_mode = 1'b0;
        win_valid    = 1'b0;
        res_ready    = 1'b0;
        repeat (3) cyc();
        chk("rst_det",     32'(seq_detected), 32'd0);
        chk("rst_valid",   32'(res_valid),    32'd0);
        chk("rst_count",   32'(res_count),    32'd0);
        chk("rst_hist",    32'(res_hist),     32'd0);
        chk("rst_overrun", 32'(res_overrun),  32'd0);
        reset = 1'b1;
        cyc();

        // Overlapping 1011 over 1011011
        base = pulse_cnt;
        open_win(4'b1011, 1'b1);
        send_bits("ovl_det", 16'b1011011, 16'b0001001, 7);
        close_win();
        chk("ovl_pulses", 32'(pulse_cnt - base), 32'd2);
        chk("ovl_valid",  32'(res_valid), 32'd1);
        exp_q.push_back('{cnt: 8'd2, hist: 16'h0009, ovr: 1'b0});
        handshake("ovl_release");

        // Non-overlapping, same stream
        base = pulse_cnt;
        open_win(4'b1011, 1'b0);
        send_bits("novl_det", 16'b1011011, 16'b0001000, 7);
        close_win();
        chk("novl_pulses", 32'(pulse_cnt - base), 32'd1);
        exp_q.push_back('{cnt: 8'd1, hist: 16'h0008, ovr: 1'b0});
        handshake("novl_release");

        // Counter saturation: 300 accepted ones, with idle gaps
        base = pulse_cnt;
        open_win(4'b1111, 1'b1);
        for (int i = 0; i < 300; i++) begin
            if (i % 50 == 25) begin
                serialin  = 1'b0;
                bit_valid = 1'b0;
                cyc();
            end
            serialin  = 1'b1;
            bit_valid = 1'b1;
            cyc();
        end
        bit_valid = 1'b0;
        serialin  = 1'b0;
        close_win();
        chk("sat_pulses", 32'(pulse_cnt - base), 32'd297);
        exp_q.push_back('{cnt: 8'd255, hist: 16'hFFFF, ovr: 1'b0});
        handshake("sat_release");

        // Overrun: two windows closed with no consumer
        open_win(4'b1011, 1'b1);
        send_bits("ovr_a_det", 16'b1011, 16'b0001, 4);
        close_win();
        open_win(4'b1011, 1'b0);
        send_bits("ovr_b_det", 16'b10111011, 16'b00010001, 8);
        close_win();
        chk("ovr_flag",  32'(res_overrun), 32'd1);
        chk("ovr_count", 32'(res_count),   32'd2);
        exp_q.push_back('{cnt: 8'd2, hist: 16'h0011, ovr: 1'b1});
        handshake("ovr_release");
        chk("ovr_cleared", 32'(res_overrun), 32'd0);

        // Capture coincident with handshake
        open_win(4'b0110, 1'b1);
        send_bits("coin_c_det", 16'b0110110, 16'b0001001, 7);
        close_win();
        exp_q.push_back('{cnt: 8'd2, hist: 16'h0009, ovr: 1'b0});
        open_win(4'b1100, 1'b0);
        send_bits("coin_d_det", 16'b11001100, 16'b00010001, 8);
        win_valid = 1'b0;
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        chk("coin_valid",   32'(res_valid),   32'd1);
        chk("coin_count",   32'(res_count),   32'd2);
        chk("coin_hist",    32'(res_hist),    32'h0011);
        chk("coin_overrun", 32'(res_overrun), 32'd0);
        exp_q.push_back('{cnt: 8'd2, hist: 16'h0011, ovr: 1'b0});
        handshake("coin_release");

        // Reset mid-window with a pending result and win_valid held high
        open_win(4'b1011, 1'b1);
        send_bits("mrst_e_det", 16'b1011, 16'b0001, 4);
        close_win();
        open_win(4'b1011, 1'b1);
        send_bits("mrst_det", 16'b1011, 16'b0001, 4);
        chk("mrst_pending", 32'(res_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("mrst_det0",     32'(seq_detected), 32'd0);
        chk("mrst_valid0",   32'(res_valid),    32'd0);
        chk("mrst_count0",   32'(res_count),    32'd0);
        chk("mrst_hist0",    32'(res_hist),     32'd0);
        chk("mrst_overrun0", 32'(res_overrun),  32'd0);
        cyc();
        cyc();
        reset = 1'b1;
        base  = pulse_cnt;
        send_bits("mrst_idle_det", 16'b1011, 16'b0000, 4);
        close_win();
        cyc();
        chk("mrst_no_result", 32'(res_valid), 32'd0);
        chk("mrst_no_pulse",  32'(pulse_cnt - base), 32'd0);
        open_win(4'b1011, 1'b1);
        send_bits("mrst_after_det", 16'b1011, 16'b0001, 4);
        close_win();
        exp_q.push_back('{cnt: 8'd1, hist: 16'h0001, ovr: 1'b0});
        handshake("mrst_release");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
